// File: rtl/bcd_display_scheduler.sv
// Load/settle/capture sequencer for a shared binary-to-BCD converter plus 3-digit scan.
// Optional leading-zero blanking: define LEADING_ZERO_BLANK_EN.
module bcd_display_scheduler #(
  parameter int REFRESH_DIV = 50000,
  parameter int SETTLE_CYC  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_in,
  input  logic [7:0] value_in,
  output logic       busy_out,
  output logic       valid_out,
  output logic [7:0] conv_bin_out,
  input  logic [3:0] conv_centena_in,
  input  logic [3:0] conv_dezena_in,
  input  logic [3:0] conv_unidade_in,
  output logic [2:0] digit_sel_out,
  output logic [3:0] digit_bcd_out
);

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE
  } state_t;

  state_t        r_state;
  logic [SW-1:0] r_settle_cnt;
  logic [7:0]    r_bin;
  logic          r_busy;
  logic          r_valid;
  logic          r_pend;
  logic [7:0]    r_pend_val;
  logic [3:0]    r_cent;
  logic [3:0]    r_dez;
  logic [3:0]    r_uni;
  logic [RW-1:0] r_ref_cnt;
  logic [1:0]    r_idx;
  logic [2:0]    r_sel;
  logic [3:0]    r_bcd;

  state_t        w_state_nxt;
  logic [SW-1:0] w_settle_nxt;
  logic [7:0]    w_bin_nxt;
  logic          w_busy_nxt;
  logic          w_valid_nxt;
  logic          w_pend_nxt;
  logic [7:0]    w_pend_val_nxt;
  logic          w_capture;
  logic          w_ref_wrap;
  logic [RW-1:0] w_ref_nxt;
  logic [1:0]    w_idx_nxt;
  logic [2:0]    w_sel_nxt;
  logic [3:0]    w_bcd_nxt;
  logic          w_blank_c;
  logic          w_blank_d;

  always_comb begin
    w_state_nxt    = r_state;
    w_settle_nxt   = r_settle_cnt;
    w_bin_nxt      = r_bin;
    w_busy_nxt     = r_busy;
    w_valid_nxt    = r_valid;
    w_pend_nxt     = r_pend;
    w_pend_val_nxt = r_pend_val;
    w_capture      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (load_in) begin
          w_bin_nxt    = value_in;
          w_busy_nxt   = 1'b1;
          w_settle_nxt = '0;
          w_state_nxt  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (load_in) begin
          w_pend_nxt     = 1'b1;
          w_pend_val_nxt = value_in;
        end
        if (r_settle_cnt == SETTLE_LAST) begin
          w_state_nxt = S_CAPTURE;
        end else begin
          w_settle_nxt = r_settle_cnt + 1'b1;
        end
      end
      S_CAPTURE: begin
        w_capture   = 1'b1;
        w_valid_nxt = 1'b1;
        // a load landing in this very cycle is the newest pending request
        if (r_pend || load_in) begin
          w_bin_nxt    = load_in ? value_in : r_pend_val;
          w_pend_nxt   = 1'b0;
          w_settle_nxt = '0;
          w_state_nxt  = S_SETTLE;
        end else begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_settle_cnt <= '0;
      r_bin        <= '0;
      r_busy       <= 1'b0;
      r_valid      <= 1'b0;
      r_pend       <= 1'b0;
      r_pend_val   <= '0;
      r_cent       <= '0;
      r_dez        <= '0;
      r_uni        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_settle_cnt <= w_settle_nxt;
      r_bin        <= w_bin_nxt;
      r_busy       <= w_busy_nxt;
      r_valid      <= w_valid_nxt;
      r_pend       <= w_pend_nxt;
      r_pend_val   <= w_pend_val_nxt;
      if (w_capture) begin
        r_cent <= conv_centena_in;
        r_dez  <= conv_dezena_in;
        r_uni  <= conv_unidade_in;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  assign w_blank_c = (r_cent == 4'd0);
  assign w_blank_d = (r_cent == 4'd0) && (r_dez == 4'd0);
`else
  assign w_blank_c = 1'b0;
  assign w_blank_d = 1'b0;
`endif

  assign w_ref_wrap = (r_ref_cnt == REFRESH_LAST);
  assign w_ref_nxt  = w_ref_wrap ? '0 : r_ref_cnt + 1'b1;

  always_comb begin
    w_idx_nxt = r_idx;
    if (w_ref_wrap) begin
      w_idx_nxt = (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
    end
  end

  always_comb begin
    w_sel_nxt = 3'b111;
    w_bcd_nxt = 4'd0;
    if (r_valid) begin
      unique case (r_idx)
        2'd0: begin
          w_sel_nxt = 3'b110;
          w_bcd_nxt = r_uni;
        end
        2'd1: begin
          w_sel_nxt = w_blank_d ? 3'b111 : 3'b101;
          w_bcd_nxt = r_dez;
        end
        2'd2: begin
          w_sel_nxt = w_blank_c ? 3'b111 : 3'b011;
          w_bcd_nxt = r_cent;
        end
        default: begin
          w_sel_nxt = 3'b111;
          w_bcd_nxt = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ref_cnt <= '0;
      r_idx     <= 2'd0;
      r_sel     <= 3'b111;
      r_bcd     <= 4'd0;
    end else begin
      r_ref_cnt <= w_ref_nxt;
      r_idx     <= w_idx_nxt;
      r_sel     <= w_sel_nxt;
      r_bcd     <= w_bcd_nxt;
    end
  end

  assign busy_out      = r_busy;
  assign valid_out     = r_valid;
  assign conv_bin_out  = r_bin;
  assign digit_sel_out = r_sel;
  assign digit_bcd_out = r_bcd;

endmodule

// File: tb/tb_bcd_display_scheduler.sv
// Directed bench for bcd_display_scheduler with a behavioural converter model.
// Honours LEADING_ZERO_BLANK_EN when computing expected anode patterns.
module tb_bcd_display_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_in;
  logic [7:0] value_in;
  logic       busy_out;
  logic       valid_out;
  logic [7:0] conv_bin_out;
  logic [3:0] conv_centena_in;
  logic [3:0] conv_dezena_in;
  logic [3:0] conv_unidade_in;
  logic [2:0] digit_sel_out;
  logic [3:0] digit_bcd_out;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  bcd_display_scheduler #(
    .REFRESH_DIV(4),
    .SETTLE_CYC (1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .load_in        (load_in),
    .value_in       (value_in),
    .busy_out       (busy_out),
    .valid_out      (valid_out),
    .conv_bin_out   (conv_bin_out),
    .conv_centena_in(conv_centena_in),
    .conv_dezena_in (conv_dezena_in),
    .conv_unidade_in(conv_unidade_in),
    .digit_sel_out  (digit_sel_out),
    .digit_bcd_out  (digit_bcd_out)
  );

  always #5 clk = ~clk;

  assign conv_centena_in = 4'(conv_bin_out / 100);
  assign conv_dezena_in  = 4'((conv_bin_out / 10) % 10);
  assign conv_unidade_in = 4'(conv_bin_out % 10);

  typedef struct {
    logic [7:0] v;
    logic [3:0] c;
    logic [3:0] d;
    logic [3:0] u;
  } vec_t;

  vec_t tbl [8];

  logic       seen_u, seen_d, seen_c;
  logic [3:0] val_u, val_d, val_c;
  int         n_blank, n_other;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic observe();
    seen_u = 0; seen_d = 0; seen_c = 0;
    val_u = 4'hf; val_d = 4'hf; val_c = 4'hf;
    n_blank = 0; n_other = 0;
    repeat (12) begin
      @(negedge clk);
      case (digit_sel_out)
        3'b110: begin seen_u = 1; val_u = digit_bcd_out; end
        3'b101: begin seen_d = 1; val_d = digit_bcd_out; end
        3'b011: begin seen_c = 1; val_c = digit_bcd_out; end
        3'b111: n_blank++;
        default: n_other++;
      endcase
    end
  endtask

  task automatic check_scan(input string tag, input logic [3:0] c,
                            input logic [3:0] d, input logic [3:0] u);
    logic lit_c, lit_d;
    lit_c = !BLANK || (c != 0);
    lit_d = !BLANK || (c != 0) || (d != 0);
    observe();
    check({tag, "_u_lit"}, seen_u, 1);
    check({tag, "_u_val"}, val_u, u);
    check({tag, "_d_lit"}, seen_d, lit_d);
    if (lit_d) check({tag, "_d_val"}, val_d, d);
    check({tag, "_c_lit"}, seen_c, lit_c);
    if (lit_c) check({tag, "_c_val"}, val_c, c);
    check({tag, "_bad_sel"}, n_other, 0);
    if (lit_c && lit_d) check({tag, "_no_blank"}, n_blank, 0);
  endtask

  task automatic do_load(input logic [7:0] v, input string tag);
    int k;
    @(negedge clk);
    load_in  = 1'b1;
    value_in = v;
    @(negedge clk);
    load_in = 1'b0;
    k = 0;
    while (busy_out && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_busy_timeout"}, busy_out, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int   last_chg;
    int   n_chg;
    logic [2:0] prev;
    logic [2:0] want;

    tbl[0] = '{8'd255, 4'd2, 4'd5, 4'd5};
    tbl[1] = '{8'd5,   4'd0, 4'd0, 4'd5};
    tbl[2] = '{8'd0,   4'd0, 4'd0, 4'd0};
    tbl[3] = '{8'd123, 4'd1, 4'd2, 4'd3};
    tbl[4] = '{8'd42,  4'd0, 4'd4, 4'd2};
    tbl[5] = '{8'd100, 4'd1, 4'd0, 4'd0};
    tbl[6] = '{8'd9,   4'd0, 4'd0, 4'd9};
    tbl[7] = '{8'd10,  4'd0, 4'd1, 4'd0};

    rst = 1'b1; load_in = 1'b0; value_in = 8'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy_out, 0);
    check("rst_valid", valid_out, 0);
    check("rst_bin", conv_bin_out, 0);
    check("rst_sel", digit_sel_out, 3'b111);
    check("rst_bcd", digit_bcd_out, 0);
    repeat (8) @(negedge clk);
    check("idle_sel", digit_sel_out, 3'b111);
    check("idle_valid", valid_out, 0);

    load_in = 1'b1; value_in = 8'd255;
    @(negedge clk);
    load_in = 1'b0;
    check("lat_bin_t1", conv_bin_out, 255);
    check("lat_busy_t1", busy_out, 1);
    check("lat_valid_t1", valid_out, 0);
    @(negedge clk);
    check("lat_busy_t2", busy_out, 1);
    check("lat_valid_t2", valid_out, 0);
    @(negedge clk);
    check("lat_busy_t3", busy_out, 0);
    check("lat_valid_t3", valid_out, 1);
    repeat (2) @(negedge clk);
    check_scan("v255", 4'd2, 4'd5, 4'd5);

    for (int i = 0; i < 8; i++) begin
      do_load(tbl[i].v, $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d_bin", i), conv_bin_out, tbl[i].v);
      check_scan($sformatf("tbl%0d", i), tbl[i].c, tbl[i].d, tbl[i].u);
    end

    @(negedge clk);
    load_in = 1'b1; value_in = 8'd7;
    @(negedge clk);
    check("pend_bin_a", conv_bin_out, 7);
    check("pend_busy_a", busy_out, 1);
    value_in = 8'd100;
    @(negedge clk);
    check("pend_bin_b", conv_bin_out, 7);
    check("pend_busy_b", busy_out, 1);
    value_in = 8'd42;
    @(negedge clk);
    load_in = 1'b0;
    check("pend_bin_c", conv_bin_out, 42);
    check("pend_busy_c", busy_out, 1);
    @(negedge clk);
    check("pend_busy_d", busy_out, 1);
    check("pend_show7", digit_bcd_out,
          (digit_sel_out == 3'b110) ? 7 : 0);
    @(negedge clk);
    check("pend_busy_e", busy_out, 0);
    check("pend_bin_e", conv_bin_out, 42);
    repeat (2) @(negedge clk);
    check_scan("pend42", 4'd0, 4'd4, 4'd2);

    do_load(8'd123, "scan_pre");
    prev = digit_sel_out;
    last_chg = -1;
    n_chg = 0;
    for (int i = 0; i < 40; i++) begin
      load_in  = (i == 10);
      value_in = 8'd234;
      @(negedge clk);
      if (digit_sel_out != prev) begin
        want = (prev == 3'b110) ? 3'b101 :
               (prev == 3'b101) ? 3'b011 : 3'b110;
        check("scan_order", digit_sel_out, want);
        if (last_chg >= 0) check("scan_period", i - last_chg, 4);
        last_chg = i;
        n_chg++;
        prev = digit_sel_out;
      end
    end
    load_in = 1'b0;
    check("scan_nchg_ok", n_chg >= 8, 1);
    check("scan_bin", conv_bin_out, 234);
    check("scan_busy", busy_out, 0);
    check_scan("v234", 4'd2, 4'd3, 4'd4);

    @(negedge clk);
    load_in = 1'b1; value_in = 8'd99;
    @(negedge clk);
    value_in = 8'd50;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    load_in = 1'b0;
    check("mid_rst_busy", busy_out, 0);
    check("mid_rst_valid", valid_out, 0);
    check("mid_rst_bin", conv_bin_out, 0);
    check("mid_rst_sel", digit_sel_out, 3'b111);
    check("mid_rst_bcd", digit_bcd_out, 0);
    repeat (10) @(negedge clk);
    check("post_rst_valid", valid_out, 0);
    check("post_rst_busy", busy_out, 0);
    check("post_rst_sel", digit_sel_out, 3'b111);
    check("post_rst_bin", conv_bin_out, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

endmodule
